// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address/count width functions and default threshold constants.
package fifo_pkg;

  localparam int unsigned DEF_AE_THRESH = 2;
  // almst_full default sits this many entries below DEPTH
  localparam int unsigned DEF_AF_MARGIN = 2;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Count must reach DEPTH itself, hence one bit more than the pointers
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [ptr_width(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with threshold flags, sticky error flags and optional FWFT output.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int unsigned AE_THRESH = DEF_AE_THRESH,
  parameter int unsigned FWFT      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [WIDTH-1:0]              data_out,
  output logic [cnt_width(DEPTH)-1:0]   data_count,
  output logic                          empty,
  output logic                          full,
  output logic                          almst_empty,
  output logic                          almst_full,
  output logic                          err,
  output logic                          ovf,
  output logic                          udf
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("fifo_sync_param: DEPTH must be a power of two and at least 4");
  end
  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH < DEPTH)) begin : g_chk_thresh
    $error("fifo_sync_param: thresholds must satisfy 0 < AE_THRESH < AF_THRESH < DEPTH");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_rej;
  logic             rd_rej;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] ram_rdata;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write
  always_comb begin
    rd_acc    = rd_en & ~empty;
    wr_acc    = wr_en & (~full | rd_acc);
    wr_rej    = wr_en & ~wr_acc;
    rd_rej    = rd_en & ~rd_acc;
    count_nxt = data_count + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_count  <= '0;
      empty       <= 1'b1;
      almst_empty <= 1'b1;
      full        <= 1'b0;
      almst_full  <= 1'b0;
      err         <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      data_count  <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_C);
      almst_empty <= (count_nxt <= AE_C);
      almst_full  <= (count_nxt >= AF_C);
      err         <= wr_rej | rd_rej;
      // A fresh error wins over a simultaneous clear
      ovf         <= wr_rej | (ovf & ~err_clr);
      udf         <= rd_rej | (udf & ~err_clr);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_out = ram_rdata;
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (reset)       data_out <= '0;
      else if (rd_acc) data_out <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: standard and FWFT instances share stimulus, checked against a queue model.
module tb_fifo_sync_param;

  localparam int unsigned W = 24;
  localparam int unsigned D = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] data_in = '0;

  logic [W-1:0] dout [2];
  logic [4:0]   cnt  [2];
  logic         emp  [2];
  logic         ful  [2];
  logic         ae   [2];
  logic         af   [2];
  logic         er   [2];
  logic         ov   [2];
  logic         ud   [2];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(dout[0]), .data_count(cnt[0]), .empty(emp[0]),
    .full(ful[0]), .almst_empty(ae[0]), .almst_full(af[0]), .err(er[0]),
    .ovf(ov[0]), .udf(ud[0])
  );

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(dout[1]), .data_count(cnt[1]), .empty(emp[1]),
    .full(ful[1]), .almst_empty(ae[1]), .almst_full(af[1]), .err(er[1]),
    .ovf(ov[1]), .udf(ud[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: the FIFO contents as a queue, plus error bookkeeping
  logic [W-1:0] q [$];
  logic [W-1:0] m_dout  = '0;
  logic         m_err   = 1'b0;
  logic         m_ovf   = 1'b0;
  logic         m_udf   = 1'b0;
  logic         m_valid = 1'b0;
  logic         rd_ok;
  logic         wr_ok;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_dout  = '0;
      m_err   = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_valid = 1'b1;
    end else begin
      rd_ok = rd_en && (q.size() != 0);
      wr_ok = wr_en && ((q.size() < D) || rd_ok);
      m_err = (rd_en && !rd_ok) || (wr_en && !wr_ok);
      m_ovf = (wr_en && !wr_ok) || (m_ovf && !err_clr);
      m_udf = (rd_en && !rd_ok) || (m_udf && !err_clr);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("count[%0d]", k), 32'(cnt[k]), q.size());
        chk($sformatf("empty[%0d]", k), 32'(emp[k]), 32'(q.size() == 0));
        chk($sformatf("full[%0d]", k), 32'(ful[k]), 32'(q.size() == D));
        chk($sformatf("almst_empty[%0d]", k), 32'(ae[k]), 32'(q.size() <= 2));
        chk($sformatf("almst_full[%0d]", k), 32'(af[k]), 32'(q.size() >= D - 2));
        chk($sformatf("err[%0d]", k), 32'(er[k]), 32'(m_err));
        chk($sformatf("ovf[%0d]", k), 32'(ov[k]), 32'(m_ovf));
        chk($sformatf("udf[%0d]", k), 32'(ud[k]), 32'(m_udf));
      end
      chk("dout_std", 32'(dout[0]), 32'(m_dout));
      if (q.size() != 0) chk("dout_fwft", 32'(dout[1]), 32'(q[0]));
    end
  end

  task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                      input logic clr = 1'b0, input logic rst = 1'b0);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    err_clr = clr;
    reset   = rst;
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_count[%0d]", tag, k), 32'(cnt[k]), 0);
      chk($sformatf("%s_empty[%0d]", tag, k), 32'(emp[k]), 1);
      chk($sformatf("%s_ae[%0d]", tag, k), 32'(ae[k]), 1);
      chk($sformatf("%s_full[%0d]", tag, k), 32'(ful[k]), 0);
      chk($sformatf("%s_af[%0d]", tag, k), 32'(af[k]), 0);
      chk($sformatf("%s_err[%0d]", tag, k), 32'(er[k]), 0);
      chk($sformatf("%s_ovf[%0d]", tag, k), 32'(ov[k]), 0);
      chk($sformatf("%s_udf[%0d]", tag, k), 32'(ud[k]), 0);
    end
    chk($sformatf("%s_dout", tag), 32'(dout[0]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_reset_state("reset");

    // Fill and overflow, one write every two cycles
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, 1'b0, W'(i));
      if (i == 12) chk("af_below", 32'(af[0]), 0);
      if (i == 13) chk("af_rise", 32'(af[0]), 1);
      if (i == 15) begin
        chk("fill_count", 32'(cnt[0]), 16);
        chk("fill_full", 32'(ful[1]), 1);
      end
      if (i == 16) begin
        chk("ovf_err", 32'(er[0]), 1);
        chk("ovf_flag", 32'(ov[1]), 1);
        chk("ovf_count", 32'(cnt[1]), 16);
      end
      step(1'b0, 1'b0, '0);
      if (i == 16) chk("ovf_err_drop", 32'(er[0]), 0);
    end

    // Drain and underflow
    for (int i = 0; i < 17; i++) begin
      if (i < 16) chk("fwft_head", 32'(dout[1]), i);
      step(1'b0, 1'b1, '0);
      if (i < 16) chk("drain_dout", 32'(dout[0]), i);
      if (i == 12) chk("ae_above", 32'(ae[0]), 0);
      if (i == 13) chk("ae_rise", 32'(ae[1]), 1);
      if (i == 15) chk("drain_empty", 32'(emp[0]), 1);
      if (i == 16) begin
        chk("udf_err", 32'(er[0]), 1);
        chk("udf_flag", 32'(ud[1]), 1);
        chk("udf_hold", 32'(dout[0]), 15);
      end
    end
    step(1'b0, 1'b0, '0, 1'b1);
    chk("clr_ovf", 32'(ov[0]), 0);
    chk("clr_udf", 32'(ud[0]), 0);

    // Wrap-around
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, W'(32'h100 + i));
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b1, W'(i));
      chk("wrap_count", 32'(cnt[0]), 4);
      if (i == 0) chk("wrap_first", 32'(dout[0]), 32'h10B);
      if (i == 4) chk("wrap_cross", 32'(dout[0]), 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
    chk("wrap_last", 32'(dout[0]), 10);

    // Simultaneous read and write while full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, W'(32'h200 + i));
    step(1'b1, 1'b1, 24'hABCDEF);
    chk("full_rw_err", 32'(er[0]), 0);
    chk("full_rw_count", 32'(cnt[1]), 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("full_rw_fwft", 32'(dout[1]), 32'hABCDEF);
      step(1'b0, 1'b1, '0);
    end
    chk("full_rw_data", 32'(dout[0]), 32'hABCDEF);

    // Simultaneous read and write while empty, then clear
    step(1'b1, 1'b1, 24'h5A5A5A);
    chk("empty_rw_count", 32'(cnt[0]), 1);
    chk("empty_rw_err", 32'(er[1]), 1);
    chk("empty_rw_udf", 32'(ud[0]), 1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("empty_rw_clr", 32'(ud[1]), 0);
    chk("empty_rw_head", 32'(dout[1]), 32'h5A5A5A);
    step(1'b0, 1'b1, '0);
    chk("empty_rw_data", 32'(dout[0]), 32'h5A5A5A);

    // Reset mid-operation with a write on the reset edge
    step(1'b0, 1'b1, '0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, W'(32'h300 + i));
    chk("pre_reset_count", 32'(cnt[0]), 9);
    step(1'b1, 1'b0, 24'h3FF, 1'b0, 1'b1);
    chk_reset_state("midreset");
    step(1'b0, 1'b1, '0);
    chk("post_reset_err", 32'(er[0]), 1);
    step(1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
